// File: rtl/fpu_share_sched_if.sv
// Requester-side bundle of the shared-FPU scheduler: request handshake with
// operands, and the one-hot response handshake with the captured result.
interface fpu_share_sched_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [32*N_REQ-1:0] req_A;
    logic [32*N_REQ-1:0] req_B;
    logic [2*N_REQ-1:0]  req_operation;
    logic [N_REQ-1:0]    rsp_valid;
    logic [N_REQ-1:0]    rsp_ready;
    logic [31:0]         rsp_result;
    logic                rsp_overflow;
    logic                rsp_underflow;

    modport master (
        output req_valid, req_A, req_B, req_operation, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_overflow, rsp_underflow
    );

    modport slave (
        input  req_valid, req_A, req_B, req_operation, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_overflow, rsp_underflow
    );
endinterface

// File: rtl/fpu_share_sched.sv
// Round-robin scheduler sharing one combinational FPU between N_REQ requesters:
// latch the winner's operands, wait FPU_LAT cycles, capture and return the result.
module fpu_share_sched #(
    parameter int N_REQ   = 4,
    parameter int FPU_LAT = 1,
    parameter int GW      = 2
) (
    input  logic             clk,
    input  logic             rst,
    fpu_share_sched_if.slave bus,
    output logic [31:0]      fpu_A,
    output logic [31:0]      fpu_B,
    output logic [1:0]       fpu_operation,
    input  logic [31:0]      fpu_result,
    input  logic             fpu_overflow,
    input  logic             fpu_underflow,
    output logic             busy
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int            CW       = (FPU_LAT > 1) ? $clog2(FPU_LAT) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(FPU_LAT - 1);

    logic [1:0]    state_q, state_d;
    logic [GW-1:0] last_grant_q;
    logic [GW-1:0] grant_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   fpu_a_q, fpu_b_q;
    logic [1:0]    fpu_op_q;
    logic [31:0]   rsp_result_q;
    logic          rsp_ovf_q, rsp_unf_q;

    logic [GW-1:0] win_idx;
    logic          win_found;
    logic          rsp_done;

    logic [31:0] op_a    [N_REQ];
    logic [31:0] op_b    [N_REQ];
    logic [1:0]  op_code [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            assign op_a[gi]    = bus.req_A[32*gi +: 32];
            assign op_b[gi]    = bus.req_B[32*gi +: 32];
            assign op_code[gi] = bus.req_operation[2*gi +: 2];
            assign bus.req_ready[gi] = (state_q == ST_IDLE) && win_found && (win_idx == GW'(gi));
            assign bus.rsp_valid[gi] = (state_q == ST_RESP) && (grant_q == GW'(gi));
        end
    endgenerate

    // Two passes give the wrap: indices above last_grant first, then the rest.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!win_found && bus.req_valid[i] && (GW'(i) > last_grant_q)) begin
                win_found = 1'b1;
                win_idx   = GW'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!win_found && bus.req_valid[i] && (GW'(i) <= last_grant_q)) begin
                win_found = 1'b1;
                win_idx   = GW'(i);
            end
        end
    end

    // Only the granted bit of rsp_valid can be high, so this ignores other ready bits.
    assign rsp_done = |(bus.rsp_valid & bus.rsp_ready);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (win_found)      state_d = ST_EXEC;
            ST_EXEC: if (cnt_q == '0)    state_d = ST_RESP;
            ST_RESP: if (rsp_done)       state_d = ST_IDLE;
            default:                     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GW'(N_REQ - 1);
            grant_q      <= '0;
            cnt_q        <= '0;
            fpu_a_q      <= '0;
            fpu_b_q      <= '0;
            fpu_op_q     <= '0;
            rsp_result_q <= '0;
            rsp_ovf_q    <= 1'b0;
            rsp_unf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (win_found) begin
                        fpu_a_q  <= op_a[win_idx];
                        fpu_b_q  <= op_b[win_idx];
                        fpu_op_q <= op_code[win_idx];
                        grant_q  <= win_idx;
                        cnt_q    <= CNT_INIT;
                    end
                end
                ST_EXEC: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        rsp_result_q <= fpu_result;
                        rsp_ovf_q    <= fpu_overflow;
                        rsp_unf_q    <= fpu_underflow;
                    end
                end
                ST_RESP: begin
                    if (rsp_done) last_grant_q <= grant_q;
                end
                default: ;
            endcase
        end
    end

    assign fpu_A             = fpu_a_q;
    assign fpu_B             = fpu_b_q;
    assign fpu_operation     = fpu_op_q;
    assign bus.rsp_result    = rsp_result_q;
    assign bus.rsp_overflow  = rsp_ovf_q;
    assign bus.rsp_underflow = rsp_unf_q;
    assign busy              = (state_q != ST_IDLE);
endmodule

// File: tb/tb_fpu_share_sched.sv
// Bench for fpu_share_sched: directed scenarios plus random traffic, checked by a
// queue-based scoreboard against a real-arithmetic FPU and round-robin model.
module tb_fpu_share_sched;
    localparam int N   = 4;
    localparam int LAT = 1;

    logic clk = 1'b0;
    logic rst, rst3;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    fpu_share_sched_if #(.N_REQ(N)) bus ();
    fpu_share_sched_if #(.N_REQ(N)) bus3 ();

    logic [31:0] fA, fB, fres, fA3, fB3, fres3;
    logic [1:0]  fop, fop3;
    logic        fovf, funf, fovf3, funf3, busy, busy3;

    // Single-precision bits to real; operands used here are normal numbers or zero.
    function automatic real f2r(input logic [31:0] x);
        real m;
        int  e;
        if (x[30:0] == 31'b0) return 0.0;
        m = 1.0 + real'(x[22:0]) / 8388608.0;
        e = int'(x[30:23]) - 127;
        m = m * (2.0 ** e);
        return x[31] ? -m : m;
    endfunction

    // Reference FPU: {overflow, underflow, result}.
    function automatic logic [33:0] fpu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [1:0] op);
        real         ra, rb, r;
        logic [63:0] d;
        logic [31:0] res;
        logic        o, u;
        int          e;
        ra = f2r(a);
        rb = f2r(b);
        case (op)
            2'd0:    r = ra + rb;
            2'd1:    r = ra - rb;
            2'd2:    r = ra * rb;
            default: r = ra / rb;
        endcase
        d = $realtobits(r);
        e = int'(d[62:52]) - 1023 + 127;
        o = 1'b0;
        u = 1'b0;
        if (d[62:0] == 63'b0) res = {d[63], 31'b0};
        else if (e >= 255) begin o = 1'b1; res = {d[63], 8'hFF, 23'b0}; end
        else if (e <= 0)   begin u = 1'b1; res = {d[63], 31'b0}; end
        else res = {d[63], 8'(e), d[51:29]};
        return {o, u, res};
    endfunction

    always_comb {fovf, funf, fres}    = fpu_model(fA, fB, fop);
    always_comb {fovf3, funf3, fres3} = fpu_model(fA3, fB3, fop3);

    fpu_share_sched #(.N_REQ(N), .FPU_LAT(LAT), .GW(2)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .fpu_A(fA), .fpu_B(fB), .fpu_operation(fop),
        .fpu_result(fres), .fpu_overflow(fovf), .fpu_underflow(funf),
        .busy(busy)
    );

    fpu_share_sched #(.N_REQ(N), .FPU_LAT(3), .GW(2)) dut3 (
        .clk(clk), .rst(rst3), .bus(bus3),
        .fpu_A(fA3), .fpu_B(fB3), .fpu_operation(fop3),
        .fpu_result(fres3), .fpu_overflow(fovf3), .fpu_underflow(funf3),
        .busy(busy3)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (last + k) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    // ---------------- scoreboard monitor (main DUT) ----------------
    typedef struct {
        int          g;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [33:0] res;
        int          due;
    } txn_t;

    txn_t sbq[$];
    int   m_last = N - 1;

    always @(negedge clk) begin
        logic [N-1:0] exp_acc;
        logic [N-1:0] exp_rv;
        int           g;
        txn_t         t;
        txn_t         nt;
        if (rst) begin
            sbq.delete();
            m_last = N - 1;
        end else begin
            exp_acc = '0;
            g = -1;
            if (sbq.size() == 0) begin
                g = rr_pick(bus.req_valid, m_last);
                if (g >= 0) exp_acc[g] = 1'b1;
            end
            check("busy", 64'(busy), 64'(sbq.size() != 0));
            check("req_ready", 64'(bus.req_ready), 64'(exp_acc));
            if (sbq.size() != 0) begin
                t = sbq[0];
                exp_rv = (cyc >= t.due) ? (N'(1) << t.g) : '0;
                check("rsp_valid", 64'(bus.rsp_valid), 64'(exp_rv));
                check("fpu_inputs", {fA, fB}, {t.a, t.b});
                check("fpu_op", 64'(fop), 64'(t.op));
                if (cyc >= t.due) begin
                    check("rsp_data", 64'({bus.rsp_overflow, bus.rsp_underflow, bus.rsp_result}),
                          64'(t.res));
                    if (bus.rsp_ready[t.g]) begin
                        m_last = t.g;
                        void'(sbq.pop_front());
                    end
                end
            end else begin
                check("rsp_valid_idle", 64'(bus.rsp_valid), 64'(0));
            end
            if (g >= 0) begin
                nt.g   = g;
                nt.a   = bus.req_A[32*g +: 32];
                nt.b   = bus.req_B[32*g +: 32];
                nt.op  = bus.req_operation[2*g +: 2];
                nt.res = fpu_model(nt.a, nt.b, nt.op);
                nt.due = cyc + LAT + 1;
                sbq.push_back(nt);
                $display("accept req%0d A=%h B=%h op=%0d at cycle %0d", g, nt.a, nt.b, nt.op, cyc);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] op);
        bus.req_A[32*i +: 32]       = a;
        bus.req_B[32*i +: 32]       = b;
        bus.req_operation[2*i +: 2] = op;
    endtask

    function automatic logic [31:0] rnd_f();
        logic [31:0] r;
        r = {1'($urandom), 8'($urandom_range(150, 100)), 23'($urandom)};
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input logic [N-1:0] m);
        int k;
        k = 0;
        @(negedge clk);
        while ((bus.req_ready & m) == '0 && k < 30) begin
            @(negedge clk);
            k++;
        end
        if ((bus.req_ready & m) == '0) check("req_ready_wait", 64'(bus.req_ready), 64'(m));
    endtask

    task automatic wait_rsp(input logic [N-1:0] m);
        int k;
        k = 0;
        @(negedge clk);
        while ((bus.rsp_valid & m) == '0 && k < 30) begin
            @(negedge clk);
            k++;
        end
        if ((bus.rsp_valid & m) == '0) check("rsp_valid_wait", 64'(bus.rsp_valid), 64'(m));
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk);
        while (busy && k < 30) begin
            @(negedge clk);
            k++;
        end
        if (busy) check("idle_wait", 64'(busy), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        int          t_acc;
        logic [N-1:0] acc;
        int          k;
        int          seen;

        rst = 1'b1;
        rst3 = 1'b1;
        bus.req_valid = '0;  bus.req_A = '0;  bus.req_B = '0;  bus.req_operation = '0;
        bus.rsp_ready = '0;
        bus3.req_valid = '0; bus3.req_A = {N{32'h3F800000}}; bus3.req_B = {N{32'h40000000}};
        bus3.req_operation = '0; bus3.rsp_ready = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_req_ready", 64'(bus.req_ready), 64'(0));
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("rst_fpu_ops", {fA, fB}, 64'(0));
        check("rst_fpu_op", 64'(fop), 64'(0));
        check("rst_rsp_data", 64'({bus.rsp_overflow, bus.rsp_underflow, bus.rsp_result}), 64'(0));
        tick();
        rst = 1'b0;
        rst3 = 1'b0;
        bus.rsp_ready = '1;

        // 1.0 + 1.0 on req0: response two cycles after accept, idle the cycle after
        set_req(0, 32'h3F800000, 32'h3F800000, 2'd0);
        bus.req_valid = 4'b0001;
        wait_ready(4'b0001);
        t_acc = cyc;
        tick();
        bus.req_valid = '0;
        wait_rsp(4'b0001);
        check("t1_latency", 64'(cyc - t_acc), 64'(2));
        check("t1_rsp_valid", 64'(bus.rsp_valid), 64'(4'b0001));
        check("t1_result", 64'(bus.rsp_result), 64'(32'h40000000));
        check("t1_flags", 64'({bus.rsp_overflow, bus.rsp_underflow}), 64'(0));
        @(negedge clk);
        check("t1_idle", 64'(busy), 64'(0));
        $display("t1 add done, cycle %0d", cyc);

        // 1.0 - 1.5 on req1
        tick();
        set_req(1, 32'h3F800000, 32'h3FC00000, 2'd1);
        bus.req_valid = 4'b0010;
        wait_ready(4'b0010);
        tick();
        bus.req_valid = '0;
        wait_rsp(4'b0010);
        check("t2_rsp_valid", 64'(bus.rsp_valid), 64'(4'b0010));
        check("t2_result", 64'(bus.rsp_result), 64'(32'hBF000000));
        wait_idle();
        $display("t2 sub done, cycle %0d", cyc);

        // All requesters valid from reset: grants 0,1,2,3,0
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < N; i++)
            set_req(i, 32'h3F800000 + (32'(i) << 21), 32'h40000000 + (32'(i) << 20), 2'(i));
        bus.req_valid = '1;
        for (int j = 0; j < 5; j++) begin
            wait_ready('1);
            check("rr_order", 64'(bus.req_ready), 64'(4'b0001 << (j % N)));
        end
        tick();
        bus.req_valid = '0;
        wait_idle();
        $display("t3 round-robin done, cycle %0d", cyc);

        // Backpressure on req0 while req1 waits
        tick();
        bus.rsp_ready = '0;
        set_req(0, 32'hBFA00000, 32'h3FC00000, 2'd2);
        bus.req_valid = 4'b0001;
        wait_ready(4'b0001);
        tick();
        set_req(1, 32'h40400000, 32'h40000000, 2'd3);
        bus.req_valid = 4'b0010;
        wait_rsp(4'b0001);
        for (int j = 0; j < 5; j++) begin
            check("bp_rsp_valid", 64'(bus.rsp_valid), 64'(4'b0001));
            check("bp_result", 64'(bus.rsp_result), 64'(32'hBFF00000));
            check("bp_req1_ready", 64'(bus.req_ready[1]), 64'(0));
            @(negedge clk);
        end
        tick();
        bus.rsp_ready = 4'b0001;
        @(negedge clk);
        @(negedge clk);
        check("bp_next_grant", 64'(bus.req_ready), 64'(4'b0010));
        tick();
        bus.req_valid = '0;
        bus.rsp_ready = '1;
        wait_idle();
        $display("t4 backpressure done, cycle %0d", cyc);

        // Overflowing multiply: flags captured from the FPU
        tick();
        set_req(2, 32'h7F000000, 32'h40000000, 2'd2);
        bus.req_valid = 4'b0100;
        wait_ready(4'b0100);
        tick();
        bus.req_valid = '0;
        wait_rsp(4'b0100);
        check("t5_overflow", 64'(bus.rsp_overflow), 64'(1));
        check("t5_underflow", 64'(bus.rsp_underflow), 64'(0));
        wait_idle();
        $display("t5 flags done, cycle %0d", cyc);

        // Random traffic with random response backpressure
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            acc = bus.req_ready & bus.req_valid;
            tick();
            for (int i = 0; i < N; i++) begin
                if (acc[i] || !bus.req_valid[i]) begin
                    if ($urandom_range(3, 0) == 0) begin
                        set_req(i, rnd_f(), rnd_f(), 2'($urandom));
                        bus.req_valid[i] = 1'b1;
                    end else begin
                        bus.req_valid[i] = 1'b0;
                    end
                end
            end
            bus.rsp_ready = N'($urandom);
        end
        tick();
        bus.req_valid = '0;
        bus.rsp_ready = '1;
        wait_idle();
        $display("random phase done, cycle %0d", cyc);

        // Reset during EXEC with FPU_LAT=3: in-flight op is dropped
        tick();
        bus3.req_valid = 4'b0010;
        @(negedge clk);
        check("r3_first_grant", 64'(bus3.req_ready), 64'(4'b0010));
        tick();
        bus3.req_valid = '0;
        k = 0;
        @(negedge clk);
        while (busy3 && k < 30) begin @(negedge clk); k++; end
        check("r3_idle", 64'(busy3), 64'(0));
        tick();
        bus3.req_valid = '1;
        @(negedge clk);
        check("r3_second_grant", 64'(bus3.req_ready), 64'(4'b0100));
        tick();
        @(negedge clk);
        check("r3_in_exec", 64'(busy3), 64'(1));
        tick();
        rst3 = 1'b1;
        tick();
        rst3 = 1'b0;
        @(negedge clk);
        check("r3_busy_after_rst", 64'(busy3), 64'(0));
        check("r3_rsp_after_rst", 64'(bus3.rsp_valid), 64'(0));
        check("r3_grant_after_rst", 64'(bus3.req_ready), 64'(4'b0001));
        tick();
        bus3.req_valid = '0;
        seen = 0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (bus3.rsp_valid != '0) begin
                seen++;
                check("r3_rsp_owner", 64'(bus3.rsp_valid), 64'(4'b0001));
            end
        end
        check("r3_rsp_count", 64'(seen), 64'(1));
        $display("reset-in-exec done, cycle %0d", cyc);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fpu_share_sched.md
Name: fpu_share_sched

Overview:
- Round-robin scheduler that shares one combinational FPU (add/sub/mul/div, 2-bit operation code) between N_REQ requesters.
- Registers the winning request's operands and holds them stable on the FPU inputs. Waits FPU_LAT cycles for the result to settle, then captures it.
- Returns the result and flags to the granted requester over a valid/ready handshake.
- Sits between the requesting datapath units and the FPU instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- FPU_LAT, 1, cycles the FPU inputs are held before the result is sampled (>=1).
- GW, 2, width of the grant index (>= clog2(N_REQ)).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset. Synchronous and active-high: sampled on the rising edge of clk.
- req_valid  input  N_REQ  per-requester request valid.
- req_ready  output  N_REQ  one-hot accept; asserted only in IDLE, on the arbitration winner.
- req_A  input  32*N_REQ  operand A per requester, slice i = [32i+31:32i].
- req_B  input  32*N_REQ  operand B per requester.
- req_operation  input  2*N_REQ  per-requester op: 0 add, 1 sub, 2 mul, 3 div.
- fpu_A  output  32  registered operand A to FPU.
- fpu_B  output  32  registered operand B to FPU.
- fpu_operation  output  2  registered op to FPU.
- fpu_result  input  32  FPU ALU_output.
- fpu_overflow  input  1  FPU overflow flag.
- fpu_underflow  input  1  FPU underflow flag.
- rsp_valid  output  N_REQ  one-hot response valid to the granted requester.
- rsp_ready  input  N_REQ  per-requester response ready.
- rsp_result  output  32  captured result.
- rsp_overflow  output  1  captured overflow flag.
- rsp_underflow  output  1  captured underflow flag.
- busy  output  1  high in EXEC or RESP.

Behaviour:
- Reset (rst high at a clk edge):
  - state<=IDLE; last_grant<=N_REQ-1.
  - fpu_A, fpu_B, fpu_operation, rsp_result, rsp_overflow, rsp_underflow, cnt all <=0.
  - rsp_valid=0, req_ready=0, busy=0.
  - Reset mid-EXEC or mid-RESP drops the in-flight operation; no response is ever issued for it.
- States: IDLE, EXEC, RESP.
- IDLE:
  - Arbitration is round-robin, scanning from (last_grant+1) mod N_REQ upward with wrap; the first asserted req_valid wins (index g).
  - req_ready[g]=1 combinationally in the same cycle; the handshake completes that cycle.
  - At the edge: fpu_A/fpu_B/fpu_operation <= slices of req_A/req_B/req_operation at g; grant<=g; cnt<=FPU_LAT-1; state<=EXEC.
  - No valid requests: stay in IDLE, all req_ready=0.
- EXEC:
  - FPU inputs held constant.
  - cnt!=0: cnt<=cnt-1.
  - cnt==0: rsp_result<=fpu_result, rsp_overflow<=fpu_overflow, rsp_underflow<=fpu_underflow; state<=RESP.
- RESP:
  - rsp_valid[grant]=1; all other bits 0. rsp_result and flags held stable.
  - On rsp_ready[grant]=1: last_grant<=grant; state<=IDLE.
  - rsp_ready on non-granted bits is ignored.
  - No new request is accepted in the RESP cycle.
- Latency: accept in cycle t gives rsp_valid from cycle t+FPU_LAT+1. Minimum spacing between accepts is FPU_LAT+2 cycles.
- Requesters must hold req_* stable until req_ready. Deasserting req_valid before grant has no effect.
- fpu_* outputs keep the last operands while in IDLE; they are not cleared.
- Result and flags are passed through bit-exact. No rounding or exception logic is added.

Test Plan:
- FPU_LAT=1; req0: A=0x3F800000, B=0x3F800000, op=0, accepted cycle 0:
  - rsp_valid=0001 in cycle 2, rsp_result=0x40000000, flags 0.
  - rsp_ready held high gives return to IDLE in cycle 3.
- req1 op=1, A=0x3F800000, B=0x3FC00000 -> rsp_result=0xBF000000 (-0.5) on rsp_valid[1].
- All four req_valid held high, rsp_ready all high:
  - Grants in order 0,1,2,3,0.
  - Each op's FPU inputs match the owning requester's slice.
  - Each rsp_valid bit matches the grant.
- Backpressure: op=2, A=0xBFA00000, B=0x3FC00000:
  - rsp_ready[0]=0 for 5 cycles: rsp_valid[0] and rsp_result=0xBFF00000 stay stable; req1 pending sees req_ready[1]=0 throughout.
  - After rsp_ready[0]=1, req1 is granted next IDLE cycle.
- Flag capture: FPU model drives fpu_overflow=1 during EXEC of a mul request -> rsp_overflow=1, rsp_underflow=0 on response.
- Reset: rst pulsed in EXEC with FPU_LAT=3:
  - Next cycle state IDLE, busy=0, rsp_valid=0; no response appears for that request.
  - Next grant goes to req0 when all requesters are valid.
